// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_pkg
// Description : Shared definitions for the PWM capture block and PWM
//               generator: register addresses, CTL/STATUS bit positions,
//               capture FSM state encoding, default counter width and a
//               3-input majority helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    // Counter width shared with the PWM generator.
    localparam int c_default_cnt_bits = 10;

    // Register map.
    localparam logic [7:0] c_addr_ctl     = 8'h00;
    localparam logic [7:0] c_addr_status  = 8'h01;
    localparam logic [7:0] c_addr_high_hi = 8'h02;
    localparam logic [7:0] c_addr_high_lo = 8'h03;
    localparam logic [7:0] c_addr_per_hi  = 8'h04;
    localparam logic [7:0] c_addr_per_lo  = 8'h05;

    // CTL bit positions.
    localparam int c_ctl_en   = 7;
    localparam int c_ctl_ie   = 6;
    localparam int c_ctl_hold = 0;

    // STATUS bit positions.
    localparam int c_stat_valid = 0;
    localparam int c_stat_ovf   = 1;
    localparam int c_stat_lvl   = 2;

    // Capture FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } pwm_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : pwm_edge_sync
// Description : Brings the asynchronous PWM input into the clk_i domain with
//               a 2-flop synchronizer and produces one-cycle rise/fall
//               pulses by comparing the level with its previous value.
//               Build option PWM_CAPTURE_GLITCH_FILTER_EN inserts a 3-sample
//               majority filter after the synchronizer (rejects 1-cycle
//               pulses, adds one cycle of latency to both edges).
// Ports       : clk_i   - system clock
//               nrst_i  - asynchronous active-low reset
//               pwm_i   - asynchronous PWM input
//               level_o - synchronized (optionally filtered) level
//               rise_o  - one-cycle pulse on a 0->1 transition of level_o
//               fall_o  - one-cycle pulse on a 1->0 transition of level_o
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_edge_sync
    import pwm_pkg::*;
(
    input  logic clk_i,
    input  logic nrst_i,
    input  logic pwm_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic w_level;

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pwm_i;
            r_sync2 <= r_sync1;
        end
    end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    // Two previous synchronized samples; the majority of these and the
    // current sample needs a level to persist for two cycles to flip.
    logic [1:0] r_hist;

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_hist <= 2'b00;
        end else begin
            r_hist <= {r_hist[0], r_sync2};
        end
    end

    assign w_level = maj3(r_sync2, r_hist[0], r_hist[1]);
`else
    assign w_level = r_sync2;
`endif

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_level;
        end
    end

    assign level_o = w_level;
    assign rise_o  = w_level & ~r_prev;
    assign fall_o  = ~w_level & r_prev;

endmodule
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// Module      : pwm_capture
// Description : Measures high time and period of a PWM input in clk_i
//               cycles and presents the results through a small byte-wide
//               register file with a level interrupt.
//               Build option PWM_CAPTURE_GLITCH_FILTER_EN (see
//               pwm_edge_sync) enables a 1-cycle glitch filter.
// Ports       : clk_i     - system clock
//               nrst_i    - asynchronous active-low reset
//               b_addr_i  - register address
//               b_data_i  - register write data
//               b_data_o  - register read data (combinational)
//               b_event_i - bus strobes: bit1 write, bit0 read
//               pwm_i     - asynchronous PWM input
//               irq_o     - interrupt, STATUS.VALID & CTL.IE (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_BITS = c_default_cnt_bits
) (
    input  logic       clk_i,
    input  logic       nrst_i,
    input  logic [7:0] b_addr_i,
    input  logic [7:0] b_data_i,
    output logic [7:0] b_data_o,
    input  logic [1:0] b_event_i,
    input  logic       pwm_i,
    output logic       irq_o
);

    localparam logic [CNT_BITS-1:0] c_cnt_one = {{(CNT_BITS-1){1'b0}}, 1'b1};
    localparam logic [CNT_BITS-1:0] c_cnt_max = '1;

    pwm_state_t          r_state;
    logic [7:0]          r_ctl;
    logic                r_valid;
    logic                r_ovf;
    logic                r_irq;
    logic [CNT_BITS-1:0] r_cnt_high;
    logic [CNT_BITS-1:0] r_cnt_per;
    logic [CNT_BITS-1:0] r_res_high;
    logic [CNT_BITS-1:0] r_res_per;

    logic       w_level;
    logic       w_rise;
    logic       w_fall;
    logic       w_en;
    logic       w_ctl_wr;
    logic       w_stat_rd;
    logic       w_sat;
    logic       w_cap;
    logic       w_cap_load;
    logic       w_valid_nxt;
    logic       w_ovf_nxt;
    logic [7:0] w_ctl_nxt;
    logic [7:0] w_status;
    logic [15:0] w_high16;
    logic [15:0] w_per16;

    pwm_edge_sync u_edge_sync (
        .clk_i   (clk_i),
        .nrst_i  (nrst_i),
        .pwm_i   (pwm_i),
        .level_o (w_level),
        .rise_o  (w_rise),
        .fall_o  (w_fall)
    );

    assign w_en      = r_ctl[c_ctl_en];
    assign w_ctl_wr  = b_event_i[1] && (b_addr_i == c_addr_ctl);
    assign w_stat_rd = b_event_i[0] && (b_addr_i == c_addr_status);

    // The period counter is never below the high counter, so it alone
    // decides saturation. Saturation takes priority over a coincident edge.
    assign w_sat = w_en && ((r_state == ST_HIGH) || (r_state == ST_LOW))
                   && (r_cnt_per == c_cnt_max);

    assign w_cap      = w_en && (r_state == ST_LOW) && w_rise && !w_sat;
    assign w_cap_load = w_cap && !r_ctl[c_ctl_hold];

    // Sticky flags: a set in the same cycle as a STATUS read wins.
    assign w_valid_nxt = w_cap_load | (r_valid & ~w_stat_rd);
    assign w_ovf_nxt   = w_sat | (r_ovf & ~w_stat_rd);
    assign w_ctl_nxt   = w_ctl_wr ? b_data_i : r_ctl;

    // ------------------------------------------------------------------
    // Capture FSM and measurement counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_state    <= ST_IDLE;
            r_cnt_high <= '0;
            r_cnt_per  <= '0;
        end else if (!w_en) begin
            r_state    <= ST_IDLE;
            r_cnt_high <= '0;
            r_cnt_per  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state    <= ST_ARM;
                    r_cnt_high <= '0;
                    r_cnt_per  <= '0;
                end
                // Waits for a rise so a partially seen period is never measured.
                ST_ARM: begin
                    if (w_rise) begin
                        r_state    <= ST_HIGH;
                        r_cnt_high <= c_cnt_one;
                        r_cnt_per  <= c_cnt_one;
                    end
                end
                ST_HIGH: begin
                    if (w_sat) begin
                        r_state <= ST_ARM;
                    end else if (w_fall) begin
                        r_state   <= ST_LOW;
                        r_cnt_per <= r_cnt_per + c_cnt_one;
                    end else begin
                        r_cnt_high <= r_cnt_high + c_cnt_one;
                        r_cnt_per  <= r_cnt_per + c_cnt_one;
                    end
                end
                ST_LOW: begin
                    if (w_sat) begin
                        r_state <= ST_ARM;
                    end else if (w_rise) begin
                        r_state    <= ST_HIGH;
                        r_cnt_high <= c_cnt_one;
                        r_cnt_per  <= c_cnt_one;
                    end else begin
                        r_cnt_per <= r_cnt_per + c_cnt_one;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register file, result capture and interrupt
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_ctl      <= 8'h00;
            r_valid    <= 1'b0;
            r_ovf      <= 1'b0;
            r_irq      <= 1'b0;
            r_res_high <= '0;
            r_res_per  <= '0;
        end else begin
            r_ctl   <= w_ctl_nxt;
            r_valid <= w_valid_nxt;
            r_ovf   <= w_ovf_nxt;
            // Built from next-state values so irq_o tracks VALID/IE exactly.
            r_irq   <= w_valid_nxt & w_ctl_nxt[c_ctl_ie];
            if (w_cap_load) begin
                r_res_high <= r_cnt_high;
                r_res_per  <= r_cnt_per;
            end
        end
    end

    assign irq_o = r_irq;

    always_comb begin
        w_high16                 = 16'h0000;
        w_high16[CNT_BITS-1:0]   = r_res_high;
        w_per16                  = 16'h0000;
        w_per16[CNT_BITS-1:0]    = r_res_per;
        w_status                 = 8'h00;
        w_status[c_stat_valid]   = r_valid;
        w_status[c_stat_ovf]     = r_ovf;
        w_status[c_stat_lvl]     = w_level;
    end

    always_comb begin
        b_data_o = 8'h00;
        case (b_addr_i)
            c_addr_ctl:     b_data_o = r_ctl;
            c_addr_status:  b_data_o = w_status;
            c_addr_high_hi: b_data_o = w_high16[15:8];
            c_addr_high_lo: b_data_o = w_high16[7:0];
            c_addr_per_hi:  b_data_o = w_per16[15:8];
            c_addr_per_lo:  b_data_o = w_per16[7:0];
            default:        b_data_o = 8'h00;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_capture
// Description : Scoreboard bench for pwm_capture. Two instances share all
//               inputs: u_dut_a with CNT_BITS=11 (holds a 1024-cycle period)
//               and u_dut_b with the default width (saturates at 1023).
//               Bus reads and irq samples push expected values into queues;
//               a negedge monitor pops and compares both instances.
//               Honours PWM_CAPTURE_GLITCH_FILTER_EN for the glitch case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_capture;

    logic       clk     = 1'b0;
    logic       nrst    = 1'b0;
    logic       pwm     = 1'b0;
    logic [7:0] b_addr  = 8'h00;
    logic [7:0] b_wdata = 8'h00;
    logic [1:0] b_event = 2'b00;
    logic       irq_chk = 1'b0;
    logic [7:0] rdata_a;
    logic [7:0] rdata_b;
    logic       irq_a;
    logic       irq_b;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam logic [7:0] c_gl_high = 8'h50;
    localparam logic [7:0] c_gl_per  = 8'hC8;
`else
    localparam logic [7:0] c_gl_high = 8'h01;
    localparam logic [7:0] c_gl_per  = 8'h50;
`endif

    always #5 clk = ~clk;

    pwm_capture #(.CNT_BITS(11)) u_dut_a (
        .clk_i     (clk),
        .nrst_i    (nrst),
        .b_addr_i  (b_addr),
        .b_data_i  (b_wdata),
        .b_data_o  (rdata_a),
        .b_event_i (b_event),
        .pwm_i     (pwm),
        .irq_o     (irq_a)
    );

    pwm_capture u_dut_b (
        .clk_i     (clk),
        .nrst_i    (nrst),
        .b_addr_i  (b_addr),
        .b_data_i  (b_wdata),
        .b_data_o  (rdata_b),
        .b_event_i (b_event),
        .pwm_i     (pwm),
        .irq_o     (irq_b)
    );

    typedef struct {
        string      name;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
    } exp_t;

    exp_t q_rd[$];
    exp_t q_irq[$];

    task automatic check(input string name, input string which,
                         input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [%s]: got 0x%02h, expected 0x%02h", name, which, act, exp);
        end
    endtask

    // Monitor: compares whenever a read strobe or irq sample is presented.
    always @(negedge clk) begin
        exp_t e;
        if (b_event[0]) begin
            if (q_rd.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rd_queue: read strobe with no expectation");
            end else begin
                e = q_rd.pop_front();
                check(e.name, "a", rdata_a, e.exp_a);
                check(e.name, "b", rdata_b, e.exp_b);
            end
        end
        if (irq_chk) begin
            if (q_irq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL irq_queue: irq sample with no expectation");
            end else begin
                e = q_irq.pop_front();
                check(e.name, "a", {7'b0, irq_a}, e.exp_a);
                check(e.name, "b", {7'b0, irq_b}, e.exp_b);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input string name, input logic [7:0] addr,
                      input logic [7:0] ea, input logic [7:0] eb);
        exp_t e;
        e.name  = name;
        e.exp_a = ea;
        e.exp_b = eb;
        q_rd.push_back(e);
        b_addr  = addr;
        b_event = 2'b01;
        cyc(1);
        b_event = 2'b00;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] data);
        b_addr  = addr;
        b_wdata = data;
        b_event = 2'b10;
        cyc(1);
        b_event = 2'b00;
    endtask

    task automatic ichk(input string name, input logic ea, input logic eb);
        exp_t e;
        e.name  = name;
        e.exp_a = {7'b0, ea};
        e.exp_b = {7'b0, eb};
        q_irq.push_back(e);
        irq_chk = 1'b1;
        cyc(1);
        irq_chk = 1'b0;
    endtask

    task automatic pwm_hi(input int n);
        pwm = 1'b1;
        cyc(n);
    endtask

    task automatic pwm_lo(input int n);
        pwm = 1'b0;
        cyc(n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        // Reset state
        cyc(2);
        rd("rst_ctl", 8'h00, 8'h00, 8'h00);
        rd("rst_status", 8'h01, 8'h00, 8'h00);
        ichk("rst_irq", 1'b0, 1'b0);
        nrst = 1'b1;
        cyc(2);

        // Register access
        wr(8'h00, 8'hC2);
        rd("ctl_rb", 8'h00, 8'hC2, 8'hC2);
        wr(8'h01, 8'hFF);
        rd("status_ro", 8'h01, 8'h00, 8'h00);
        rd("unmapped", 8'h07, 8'h00, 8'h00);
        rd("high_hi_init", 8'h02, 8'h00, 8'h00);

        // 300/724 periods: instance a captures 0x12C/0x400, instance b saturates
        pwm_hi(300); pwm_lo(724);
        pwm_hi(300); pwm_lo(724);
        pwm_hi(6);
        ichk("irq_cap1024", 1'b1, 1'b0);
        rd("high_hi_1024", 8'h02, 8'h01, 8'h00);
        rd("high_lo_1024", 8'h03, 8'h2C, 8'h00);
        rd("per_hi_1024", 8'h04, 8'h04, 8'h00);
        rd("per_lo_1024", 8'h05, 8'h00, 8'h00);
        rd("status_1024", 8'h01, 8'h05, 8'h06);
        ichk("irq_after_rd", 1'b0, 1'b0);
        rd("status_cleared", 8'h01, 8'h04, 8'h04);

        // 100/200 periods, then HOLD while input moves to 50/400
        pwm_lo(200);
        pwm_hi(100); pwm_lo(100);
        pwm_hi(100); pwm_lo(100);
        pwm_hi(6);
        ichk("irq_cap200", 1'b1, 1'b1);
        rd("high_hi_200", 8'h02, 8'h00, 8'h00);
        rd("high_lo_200", 8'h03, 8'h64, 8'h64);
        rd("per_hi_200", 8'h04, 8'h00, 8'h00);
        rd("per_lo_200", 8'h05, 8'hC8, 8'hC8);
        rd("status_200", 8'h01, 8'h05, 8'h05);
        wr(8'h00, 8'hC3);
        pwm_lo(350);
        pwm_hi(50); pwm_lo(350);
        pwm_hi(6);
        rd("hold_high_lo", 8'h03, 8'h64, 8'h64);
        rd("hold_per_lo", 8'h05, 8'hC8, 8'hC8);
        rd("hold_per_hi", 8'h04, 8'h00, 8'h00);
        rd("hold_status", 8'h01, 8'h04, 8'h04);
        ichk("hold_irq", 1'b0, 1'b0);
        wr(8'h00, 8'hC2);
        cyc(38);
        pwm_lo(350);
        pwm_hi(6);
        ichk("irq_cap400", 1'b1, 1'b1);
        rd("high_lo_400", 8'h03, 8'h32, 8'h32);
        rd("per_hi_400", 8'h04, 8'h01, 8'h01);
        rd("per_lo_400", 8'h05, 8'h90, 8'h90);

        // Held high: instance b saturates, keeps results and VALID
        cyc(1100);
        rd("ovf_high_lo", 8'h03, 8'h32, 8'h32);
        ichk("ovf_irq", 1'b1, 1'b1);
        rd("ovf_status", 8'h01, 8'h05, 8'h07);
        pwm_lo(1000);
        rd("ovf_a_status", 8'h01, 8'h02, 8'h00);
        ichk("ovf_a_irq", 1'b0, 1'b0);
        pwm_hi(100); pwm_lo(100);
        pwm_hi(6);
        rd("rearm_high_lo", 8'h03, 8'h64, 8'h64);
        rd("rearm_per_lo", 8'h05, 8'hC8, 8'hC8);
        ichk("rearm_irq", 1'b1, 1'b1);

        // Reset in the middle of a high phase
        nrst = 1'b0;
        cyc(1);
        rd("mid_rst_ctl", 8'h00, 8'h00, 8'h00);
        rd("mid_rst_high_lo", 8'h03, 8'h00, 8'h00);
        rd("mid_rst_per_lo", 8'h05, 8'h00, 8'h00);
        rd("mid_rst_status", 8'h01, 8'h00, 8'h00);
        ichk("mid_rst_irq", 1'b0, 1'b0);
        nrst = 1'b1;
        cyc(4);
        wr(8'h00, 8'hC2);
        cyc(10);
        pwm_lo(50);
        pwm_hi(70); pwm_lo(130);
        pwm_hi(6);
        rd("post_rst_high_lo", 8'h03, 8'h46, 8'h46);
        rd("post_rst_per_lo", 8'h05, 8'hC8, 8'hC8);
        rd("post_rst_status", 8'h01, 8'h05, 8'h05);

        // One-cycle glitch during the low phase
        pwm_lo(100);
        pwm_hi(80); pwm_lo(40);
        pwm_hi(1); pwm_lo(79);
        pwm_hi(6);
        rd("glitch_high_lo", 8'h03, c_gl_high, c_gl_high);
        rd("glitch_per_lo", 8'h05, c_gl_per, c_gl_per);
        rd("glitch_per_hi", 8'h04, 8'h00, 8'h00);

        cyc(2);
        if (q_rd.size() != 0 || q_irq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d reads and %0d irq samples left unchecked",
                     q_rd.size(), q_irq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
